// File: rtl/fp_pkg.sv
// Shared constants, field helpers and FSM encoding for the FP multiply scheduler.
package fp_pkg;

  localparam int NB_MANT_DEF  = 8;
  localparam int NB_EXP_DEF   = 4;
  localparam int NB_FLOAT_DEF = 1 + NB_EXP_DEF + NB_MANT_DEF;

  // Exponent bias for a given exponent width (7 for a 4-bit exponent).
  function automatic int bias(input int nb_exp);
    return (1 << (nb_exp - 1)) - 1;
  endfunction

  // Bit position of the sign in a packed {sign, exp, mant} word.
  function automatic int sign_pos(input int nb_exp, input int nb_mant);
    return nb_exp + nb_mant;
  endfunction

  // Least significant bit of the exponent field in a packed word.
  function automatic int exp_lsb(input int nb_mant);
    return nb_mant;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/fp_mant_mul.sv
// Combinational mantissa multiplier with hidden leading one; renormalises by
// one position when the product reaches 2.0 and truncates the rest.
module fp_mant_mul #(
  parameter int NB_MANT = 8,
  parameter int NB_EXP  = 4
) (
  input  logic [NB_MANT-1:0] MANT_A,
  input  logic [NB_MANT-1:0] MANT_B,
  input  logic [NB_EXP-1:0]  EXP,
  output logic [NB_MANT-1:0] MANT_C,
  output logic [NB_EXP-1:0]  EXP_C
);

  localparam int NB_PROD = 2 * NB_MANT + 2;

  logic [NB_PROD-1:0] op_a;
  logic [NB_PROD-1:0] op_b;
  logic [NB_MANT+1:0] prod_hi;

  // Multiply 1.MANT_A by 1.MANT_B, keep the integer bits plus the upper fraction.
  always_comb begin
    op_a    = {{(NB_MANT + 1){1'b0}}, 1'b1, MANT_A};
    op_b    = {{(NB_MANT + 1){1'b0}}, 1'b1, MANT_B};
    prod_hi = (NB_MANT + 2)'((op_a * op_b) >> NB_MANT);
  end

  // Shift right and bump the exponent when the product is in [2.0, 4.0).
  always_comb begin
    if (prod_hi[NB_MANT+1]) begin
      MANT_C = prod_hi[NB_MANT:1];
      EXP_C  = EXP + 1'b1;
    end else begin
      MANT_C = prod_hi[NB_MANT-1:0];
      EXP_C  = EXP;
    end
  end

endmodule

// File: rtl/fp_mul_scheduler.sv
// Round-robin scheduler sharing one mantissa multiplier between two
// requesters; computes sign/exponent, flags zero/overflow/underflow and
// returns a registered, tagged result over valid/ready.
module fp_mul_scheduler
  import fp_pkg::*;
#(
  parameter int NB_MANT = NB_MANT_DEF,
  parameter int NB_EXP  = NB_EXP_DEF
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    REQ0_VALID,
  output logic                    REQ0_READY,
  input  logic [NB_EXP+NB_MANT:0] REQ0_A,
  input  logic [NB_EXP+NB_MANT:0] REQ0_B,
  input  logic                    REQ1_VALID,
  output logic                    REQ1_READY,
  input  logic [NB_EXP+NB_MANT:0] REQ1_A,
  input  logic [NB_EXP+NB_MANT:0] REQ1_B,
  output logic                    RES_VALID,
  input  logic                    RES_READY,
  output logic [NB_EXP+NB_MANT:0] RES,
  output logic                    RES_ID,
  output logic                    RES_OVF,
  output logic                    RES_UNF
);

  localparam int NB_FLOAT = 1 + NB_EXP + NB_MANT;
  localparam int SIGN_POS = sign_pos(NB_EXP, NB_MANT);
  localparam int EXP_LSB  = exp_lsb(NB_MANT);
  localparam int NB_EW    = NB_EXP + 2;
  localparam logic [NB_EW-1:0] BIAS_W  = NB_EW'(bias(NB_EXP));
  localparam logic [NB_EW-1:0] EXP_MAX = NB_EW'((1 << NB_EXP) - 1);

  state_t state_q;
  state_t state_d;

  logic                last_q;
  logic                grant_id;
  logic                handshake;
  logic [NB_FLOAT-1:0] op_a_q;
  logic [NB_FLOAT-1:0] op_b_q;
  logic                id_q;

  logic [NB_EXP-1:0]   ea;
  logic [NB_EXP-1:0]   eb;
  logic [NB_EW-1:0]    exp_raw;
  logic [NB_EW-1:0]    exp_fin;
  logic [NB_EXP-1:0]   exp_drv;
  logic [NB_MANT-1:0]  mant_c;
  logic [NB_EXP-1:0]   exp_c;
  logic                norm;
  logic                sign_c;
  logic                zero_c;

  logic [NB_FLOAT-1:0] res_d;
  logic                ovf_d;
  logic                unf_d;
  logic [NB_FLOAT-1:0] res_q;
  logic                res_id_q;
  logic                res_ovf_q;
  logic                res_unf_q;

  // Round-robin grant: a lone requester wins, on contention the one not served last wins.
  always_comb begin
    if (REQ0_VALID && REQ1_VALID) begin
      grant_id = ~last_q;
    end else begin
      grant_id = REQ1_VALID;
    end
  end

  assign handshake = (state_q == IDLE) && (REQ0_VALID || REQ1_VALID);

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: one grant, one multiply cycle, then hold until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (RES_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ready only toward the granted requester while idle.
  always_comb begin
    REQ0_READY = (state_q == IDLE) && REQ0_VALID && !grant_id;
    REQ1_READY = (state_q == IDLE) && REQ1_VALID &&  grant_id;
    RES_VALID  = (state_q == RESP);
  end

  // Capture the granted operand pair and remember who was served.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_a_q <= '0;
      op_b_q <= '0;
      id_q   <= 1'b0;
      last_q <= 1'b1;
    end else if (handshake) begin
      op_a_q <= grant_id ? REQ1_A : REQ0_A;
      op_b_q <= grant_id ? REQ1_B : REQ0_B;
      id_q   <= grant_id;
      last_q <= grant_id;
    end
  end

  // Exponent sum before renormalisation; its low bits feed the multiplier.
  always_comb begin
    ea      = op_a_q[EXP_LSB +: NB_EXP];
    eb      = op_b_q[EXP_LSB +: NB_EXP];
    exp_raw = {2'b00, ea} + {2'b00, eb} - BIAS_W;
    exp_drv = exp_raw[NB_EXP-1:0];
  end

  fp_mant_mul #(
    .NB_MANT (NB_MANT),
    .NB_EXP  (NB_EXP)
  ) u_mant_mul (
    .MANT_A (op_a_q[NB_MANT-1:0]),
    .MANT_B (op_b_q[NB_MANT-1:0]),
    .EXP    (exp_drv),
    .MANT_C (mant_c),
    .EXP_C  (exp_c)
  );

  // Final exponent and special cases; a zero operand overrides range checks.
  always_comb begin
    sign_c  = op_a_q[SIGN_POS] ^ op_b_q[SIGN_POS];
    zero_c  = (ea == '0) || (eb == '0);
    norm    = (exp_c != exp_drv);
    exp_fin = exp_raw + NB_EW'(norm);
    res_d   = {sign_c, exp_fin[NB_EXP-1:0], mant_c};
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (zero_c) begin
      res_d = {sign_c, {(NB_FLOAT - 1){1'b0}}};
    end else if ($signed(exp_fin) > $signed(EXP_MAX)) begin
      res_d = {sign_c, {(NB_FLOAT - 1){1'b1}}};
      ovf_d = 1'b1;
    end else if (exp_fin[NB_EW-1] || (exp_fin == '0)) begin
      res_d = {sign_c, {(NB_FLOAT - 1){1'b0}}};
      unf_d = 1'b1;
    end
  end

  // Result registers load in EXEC and stay put while the consumer stalls.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      res_q     <= '0;
      res_id_q  <= 1'b0;
      res_ovf_q <= 1'b0;
      res_unf_q <= 1'b0;
    end else if (state_q == EXEC) begin
      res_q     <= res_d;
      res_id_q  <= id_q;
      res_ovf_q <= ovf_d;
      res_unf_q <= unf_d;
    end
  end

  assign RES     = res_q;
  assign RES_ID  = res_id_q;
  assign RES_OVF = res_ovf_q;
  assign RES_UNF = res_unf_q;

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Self-checking bench for fp_mul_scheduler: directed arithmetic cases,
// contention, backpressure, reset mid-operation and randomized traffic.
module tb_fp_mul_scheduler;

  logic        CLK;
  logic        RST_N;
  logic        REQ0_VALID;
  logic        REQ0_READY;
  logic [12:0] REQ0_A;
  logic [12:0] REQ0_B;
  logic        REQ1_VALID;
  logic        REQ1_READY;
  logic [12:0] REQ1_A;
  logic [12:0] REQ1_B;
  logic        RES_VALID;
  logic        RES_READY;
  logic [12:0] RES;
  logic        RES_ID;
  logic        RES_OVF;
  logic        RES_UNF;

  int checks = 0;
  int errors = 0;

  fp_mul_scheduler dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .REQ0_VALID (REQ0_VALID),
    .REQ0_READY (REQ0_READY),
    .REQ0_A     (REQ0_A),
    .REQ0_B     (REQ0_B),
    .REQ1_VALID (REQ1_VALID),
    .REQ1_READY (REQ1_READY),
    .REQ1_A     (REQ1_A),
    .REQ1_B     (REQ1_B),
    .RES_VALID  (RES_VALID),
    .RES_READY  (RES_READY),
    .RES        (RES),
    .RES_ID     (RES_ID),
    .RES_OVF    (RES_OVF),
    .RES_UNF    (RES_UNF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: real-valued product of 1.m mantissas, scaled by 2^16, truncated.
  // Returns {ovf, unf, result}.
  function automatic logic [14:0] model(input logic [12:0] a, input logic [12:0] b);
    int ea, eb, ma, mb, p, e, m;
    logic s;
    s  = a[12] ^ b[12];
    ea = int'(a[11:8]);
    eb = int'(b[11:8]);
    ma = int'(a[7:0]);
    mb = int'(b[7:0]);
    if (ea == 0 || eb == 0) return {2'b00, s, 12'd0};
    p = (256 + ma) * (256 + mb);
    e = ea + eb - 7;
    if (p >= 131072) begin
      e = e + 1;
      m = (p / 512) % 256;
    end else begin
      m = (p / 256) % 256;
    end
    if (e > 15) return {2'b10, s, 12'hFFF};
    if (e <= 0) return {2'b01, s, 12'd0};
    return {2'b00, s, e[3:0], m[7:0]};
  endfunction

  function automatic logic [12:0] rand_float();
    logic [3:0] e;
    logic [7:0] m;
    logic s;
    s = 1'($urandom_range(0, 1));
    e = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    m = 8'($urandom_range(0, 255));
    return {s, e, m};
  endfunction

  function automatic logic ready_of(input logic id);
    return id ? REQ1_READY : REQ0_READY;
  endfunction

  task automatic apply_reset();
    RST_N      = 1'b0;
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    REQ0_A = '0; REQ0_B = '0; REQ1_A = '0; REQ1_B = '0;
    RES_READY  = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  // Wait (bounded) for any grant; returns 1 if one appeared.
  task automatic wait_grant(output logic ok);
    int cnt;
    cnt = 0;
    #1;
    while (!(REQ0_READY || REQ1_READY) && cnt < 20) begin
      @(negedge CLK); #1;
      cnt++;
    end
    ok = REQ0_READY || REQ1_READY;
  endtask

  // Single request from one requester, consumer stalls for 'hold' cycles.
  task automatic do_op(input logic id, input logic [12:0] a, input logic [12:0] b,
                       input logic [14:0] exp_v, input int hold, input string tag);
    logic ok;
    @(negedge CLK);
    RES_READY = 1'b0;
    if (id) begin REQ1_A = a; REQ1_B = b; REQ1_VALID = 1'b1; end
    else    begin REQ0_A = a; REQ0_B = b; REQ0_VALID = 1'b1; end
    wait_grant(ok);
    checks++;
    if (!ok || !ready_of(id) || ready_of(!id)) begin
      errors++;
      $display("[TB] FAIL %s grant: ready0=%b ready1=%b, required ready%0d only",
               tag, REQ0_READY, REQ1_READY, id);
      REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
      return;
    end
    @(posedge CLK); #1;
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    checks++;
    if (RES_VALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s exec_valid: got %b, required 0", tag, RES_VALID);
    end
    @(posedge CLK); #1;
    checks++;
    if (RES_VALID !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s latency: RES_VALID=%b at N+2, required 1", tag, RES_VALID);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK); #1;
      checks++;
      if (RES_VALID !== 1'b1 || RES !== exp_v[12:0] || REQ0_READY !== 1'b0 || REQ1_READY !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s hold: valid=%b res=%b rdy=%b%b, required 1 %b 00",
                 tag, RES_VALID, RES, REQ0_READY, REQ1_READY, exp_v[12:0]);
      end
    end
    checks++;
    if ({RES_OVF, RES_UNF, RES} !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s result: got ovf=%b unf=%b res=%b, required ovf=%b unf=%b res=%b",
               tag, RES_OVF, RES_UNF, RES, exp_v[14], exp_v[13], exp_v[12:0]);
    end
    checks++;
    if (RES_ID !== id) begin
      errors++;
      $display("[TB] FAIL %s res_id: got %b, required %b", tag, RES_ID, id);
    end
    RES_READY = 1'b1;
    @(posedge CLK); #1;
    RES_READY = 1'b0;
    checks++;
    if (RES_VALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s release: RES_VALID=%b, required 0", tag, RES_VALID);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({RES_VALID, RES, RES_ID, RES_OVF, RES_UNF, REQ0_READY, REQ1_READY} !== 19'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: valid=%b res=%b id=%b ovf=%b unf=%b, required all 0",
               RES_VALID, RES, RES_ID, RES_OVF, RES_UNF);
    end
  endtask

  task automatic test_arith();
    do_op(1'b0, 13'b0_0111_10000000, 13'b0_0111_10000000, {2'b00, 13'b0_1000_00100000}, 0, "renorm");
    do_op(1'b1, 13'b0_0111_00000000, 13'b1_0111_00000000, {2'b00, 13'b1_0111_00000000}, 1, "neg_one");
    do_op(1'b0, 13'b0_1110_00000000, 13'b0_1110_00000000, {2'b10, 13'b0_1111_11111111}, 0, "overflow");
    do_op(1'b1, 13'b0_0010_00000000, 13'b0_0010_00000000, {2'b01, 13'b0_0000_00000000}, 0, "underflow");
    do_op(1'b0, 13'b1_0000_00000000, 13'b0_1110_11111111, {2'b00, 13'b1_0000_00000000}, 2, "zero");
  endtask

  // Both requesters always valid: grants must alternate starting with 0.
  task automatic test_contention();
    logic        ok;
    logic        exp_id;
    logic        g;
    logic [14:0] exp_v;
    apply_reset();
    REQ0_A = rand_float(); REQ0_B = rand_float();
    REQ1_A = 13'b0_0111_00000000; REQ1_B = 13'b1_0111_00000000;
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1; RES_READY = 1'b1;
    exp_id = 1'b0;
    for (int k = 0; k < 8; k++) begin
      wait_grant(ok);
      g = REQ1_READY;
      checks++;
      if (!ok || (REQ0_READY && REQ1_READY) || g !== exp_id) begin
        errors++;
        $display("[TB] FAIL contention_grant[%0d]: ready0=%b ready1=%b, required ready%0d only",
                 k, REQ0_READY, REQ1_READY, exp_id);
        break;
      end
      exp_v = g ? model(REQ1_A, REQ1_B) : model(REQ0_A, REQ0_B);
      @(posedge CLK); #1;
      if (g) begin REQ1_A = rand_float(); REQ1_B = rand_float(); end
      else   begin REQ0_A = rand_float(); REQ0_B = rand_float(); end
      @(posedge CLK); #1;
      checks++;
      if (RES_VALID !== 1'b1 || {RES_OVF, RES_UNF, RES} !== exp_v || RES_ID !== exp_id) begin
        errors++;
        $display("[TB] FAIL contention_result[%0d]: valid=%b id=%b flags=%b%b res=%b, required 1 %b %b %b",
                 k, RES_VALID, RES_ID, RES_OVF, RES_UNF, RES, exp_id, exp_v[14:13], exp_v[12:0]);
      end
      exp_id = ~exp_id;
    end
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0; RES_READY = 1'b0;
    @(negedge CLK);
  endtask

  // Stalled consumer: result frozen, no grants, then the waiting requester wins.
  task automatic test_back_to_back();
    logic        ok;
    logic [14:0] exp_v;
    logic [12:0] snap;
    apply_reset();
    REQ0_A = rand_float(); REQ0_B = rand_float();
    REQ1_A = rand_float(); REQ1_B = rand_float();
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1; RES_READY = 1'b0;
    wait_grant(ok);
    checks++;
    if (!ok || REQ0_READY !== 1'b1 || REQ1_READY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_first_grant: ready0=%b ready1=%b, required 1 0", REQ0_READY, REQ1_READY);
    end
    exp_v = model(REQ0_A, REQ0_B);
    @(posedge CLK); #1;
    REQ0_A = rand_float(); REQ0_B = rand_float();
    @(posedge CLK); #1;
    snap = RES;
    checks++;
    if (RES_VALID !== 1'b1 || {RES_OVF, RES_UNF, RES} !== exp_v) begin
      errors++;
      $display("[TB] FAIL bp_result: valid=%b flags=%b%b res=%b, required 1 %b %b",
               RES_VALID, RES_OVF, RES_UNF, RES, exp_v[14:13], exp_v[12:0]);
    end
    for (int h = 0; h < 5; h++) begin
      @(negedge CLK); #1;
      checks++;
      if (RES_VALID !== 1'b1 || RES !== exp_v[12:0] || REQ0_READY !== 1'b0 || REQ1_READY !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: valid=%b res=%b (was %b) rdy=%b%b, required 1 %b 00",
                 h, RES_VALID, RES, snap, REQ0_READY, REQ1_READY, exp_v[12:0]);
      end
    end
    RES_READY = 1'b1;
    @(posedge CLK); #1;
    RES_READY = 1'b0;
    checks++;
    if (REQ1_READY !== 1'b1 || REQ0_READY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_next_grant: ready0=%b ready1=%b, required 0 1", REQ0_READY, REQ1_READY);
    end
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    @(negedge CLK);
  endtask

  // Reset while in EXEC (stage 0) or RESP (stage 1).
  task automatic test_reset_mid(input int stage);
    logic ok;
    apply_reset();
    REQ1_A = rand_float(); REQ1_B = rand_float();
    REQ1_VALID = 1'b1;
    wait_grant(ok);
    @(posedge CLK); #1;
    REQ1_VALID = 1'b0;
    if (stage == 1) begin
      @(posedge CLK); #1;
      checks++;
      if (RES_VALID !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rst_mid_pre: RES_VALID=%b, required 1", RES_VALID);
      end
    end
    RST_N = 1'b0;
    #1;
    checks++;
    if (RES_VALID !== 1'b0 || RES !== 13'd0 || RES_ID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_stage%0d: valid=%b res=%b id=%b, required 0 0 0",
               stage, RES_VALID, RES, RES_ID);
    end
    #2;
    RST_N = 1'b1;
    @(negedge CLK);
    REQ0_A = rand_float(); REQ0_B = rand_float();
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    #1;
    checks++;
    if (REQ0_READY !== 1'b1 || REQ1_READY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_regrant%0d: ready0=%b ready1=%b, required 1 0",
               stage, REQ0_READY, REQ1_READY);
    end
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_random();
    logic        id;
    logic [12:0] a;
    logic [12:0] b;
    apply_reset();
    for (int k = 0; k < 30; k++) begin
      id = 1'($urandom_range(0, 1));
      a  = rand_float();
      b  = rand_float();
      do_op(id, a, b, model(a, b), $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_arith();
    test_contention();
    test_back_to_back();
    test_reset_mid(0);
    test_reset_mid(1);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
